// File: rtl/mrhy4_sub_sched.sv
// Round-robin word scheduler for one shared digit-serial mrHY4 subtractor.
// Optional macro MRHY4_SCHED_PRIO_EN gives requester 0 fixed priority at arbitration points.
module mrhy4_sub_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NDIG  = 16,
  parameter int unsigned DELTA = 1,
  localparam int unsigned SW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            stall,
  output logic [NREQ-1:0] gnt,
  output logic [SW-1:0]   sel,
  output logic            dig_rdy,
  output logic            zero_dig,
  output logic            sub_clr,
  output logic            out_vld,
  output logic            out_first,
  output logic            out_last,
  output logic [SW-1:0]   out_id,
  output logic            busy
);

  localparam int unsigned KW = $clog2(NDIG + DELTA);
  localparam int unsigned DW = $clog2(NDIG);
  localparam logic [KW-1:0] KFirst = KW'(DELTA);
  localparam logic [KW-1:0] KLast  = KW'(NDIG + DELTA - 1);
  localparam logic [DW-1:0] DLast  = DW'(NDIG - 1);

  typedef enum logic [1:0] {StIdle, StClear, StRun, StFlush} state_e;

  state_e          r_state;
  logic [NREQ-1:0] r_gnt;
  logic [SW-1:0]   r_sel;
  logic [SW-1:0]   r_ptr;
  logic [DW-1:0]   r_dig;
  logic [KW-1:0]   r_k;

  logic            w_any;
  logic            w_found;
  logic [SW-1:0]   w_win;
  logic [SW-1:0]   w_ptr_nxt;
  logic [SW-1:0]   w_idx;
  logic [NREQ-1:0] w_oh;
  logic            w_act;
  int              w_pos;

  // Search starts one past the last winner and wraps around.
  always_comb begin
    w_any   = |req;
    w_found = 1'b0;
    w_win   = '0;
    w_pos   = 0;
    w_idx   = '0;
    for (int i = 1; i <= int'(NREQ); i++) begin
      w_pos = int'(r_ptr) + i;
      if (w_pos >= int'(NREQ)) w_pos = w_pos - int'(NREQ);
      w_idx = SW'(w_pos);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
    w_ptr_nxt = w_win;
`ifdef MRHY4_SCHED_PRIO_EN
    if (req[0]) begin
      w_win     = '0;
      w_ptr_nxt = r_ptr;
    end
`endif
    w_oh        = '0;
    w_oh[w_win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_ptr   <= SW'(NREQ - 1);
      r_dig   <= '0;
      r_k     <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_any) begin
            r_gnt   <= w_oh;
            r_sel   <= w_win;
            r_ptr   <= w_ptr_nxt;
            r_state <= StClear;
          end
        end
        StClear: begin
          r_dig   <= '0;
          r_k     <= '0;
          r_state <= StRun;
        end
        StRun: begin
          if (!stall) begin
            r_k <= r_k + KW'(1);
            if (r_dig == DLast) r_state <= StFlush;
            else                r_dig   <= r_dig + DW'(1);
          end
        end
        StFlush: begin
          if (!stall) begin
            if (r_k == KLast) begin
              r_k   <= '0;
              r_dig <= '0;
              // Next word is granted straight from flush, no idle gap.
              if (w_any) begin
                r_gnt   <= w_oh;
                r_sel   <= w_win;
                r_ptr   <= w_ptr_nxt;
                r_state <= StClear;
              end else begin
                r_gnt   <= '0;
                r_sel   <= '0;
                r_state <= StIdle;
              end
            end else begin
              r_k <= r_k + KW'(1);
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign w_act     = (r_state == StRun) || (r_state == StFlush);
  assign gnt       = r_gnt;
  assign sel       = r_sel;
  assign busy      = (r_state != StIdle);
  assign dig_rdy   = (r_state == StRun) && !stall;
  assign zero_dig  = (r_state == StFlush);
  assign sub_clr   = !rst_n || (r_state == StClear);
  assign out_vld   = w_act && !stall && (r_k >= KFirst);
  assign out_first = out_vld && (r_k == KFirst);
  assign out_last  = out_vld && (r_k == KLast);
  assign out_id    = w_act ? r_sel : '0;

endmodule

// File: tb/tb_mrhy4_sub_sched.sv
// Scoreboard bench for mrhy4_sub_sched: word-level arbitration model plus per-word timing rules.
module tb_mrhy4_sub_sched;
  localparam int NREQ  = 4;
  localparam int NDIG  = 8;
  localparam int DELTA = 1;
  localparam int WLEN  = 1 + NDIG + DELTA;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic       stall = 1'b0;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic [1:0] out_id;
  logic       dig_rdy, zero_dig, sub_clr, out_vld, out_first, out_last, busy;

  always #5 clk = ~clk;

  mrhy4_sub_sched #(.NREQ(NREQ), .NDIG(NDIG), .DELTA(DELTA)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .stall(stall), .gnt(gnt), .sel(sel),
    .dig_rdy(dig_rdy), .zero_dig(zero_dig), .sub_clr(sub_clr), .out_vld(out_vld),
    .out_first(out_first), .out_last(out_last), .out_id(out_id), .busy(busy)
  );

  typedef struct {int id; int first; int last;} beat_t;
  beat_t exp_beats[$];
  int    exp_gnts[$];
  int    got_gnts[$];
  int    errors = 0, checks = 0;
  int    m_ptr = NREQ - 1;
  int    clr_cnt = 0, busy_cyc = 0, cyc = 0;
  bit    stall_en = 1'b0;
  bit    in_word = 1'b0;
  int    w_ncyc, w_dcnt, w_zcnt, w_first_at;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int oh2idx(input logic [3:0] g);
    if ($countones(g) != 1) return -1;
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return -1;
  endfunction

  // Reference: which requester wins the next word given the req value seen at that point.
  task automatic model_word(input logic [3:0] r);
    int w;
    w = -1;
`ifdef MRHY4_SCHED_PRIO_EN
    if (r[0]) w = 0;
`endif
    for (int s = 1; s <= NREQ; s++) begin
      int c;
      c = (m_ptr + s) % NREQ;
      if (w < 0 && r[c]) begin
        w = c;
        m_ptr = c;
      end
    end
    exp_gnts.push_back(w);
    for (int b = 0; b < NDIG; b++) begin
      beat_t bt;
      bt.id = w; bt.first = (b == 0); bt.last = (b == NDIG - 1);
      exp_beats.push_back(bt);
    end
  endtask

  task automatic close_word();
    chk("word_nonstall_cycles", w_ncyc, NDIG + DELTA);
    chk("word_dig_rdy", w_dcnt, NDIG);
    chk("word_flush_cycles", w_zcnt, DELTA);
    chk("word_first_k", w_first_at, DELTA);
    in_word = 1'b0;
  endtask

  task automatic monitor();
    int gid, e;
    beat_t bt;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        in_word = 1'b0;
        continue;
      end
      if (busy) busy_cyc++;
      if (in_word && (sub_clr || !busy)) close_word();
      if (sub_clr) begin
        clr_cnt++;
        gid = oh2idx(gnt);
        got_gnts.push_back(gid);
        if (exp_gnts.size() == 0) chk("unexpected_grant", gid, -1);
        else begin
          e = exp_gnts.pop_front();
          chk("gnt_owner", gid, e);
          chk("sel", int'(sel), e);
        end
        chk("clear_quiet", int'({dig_rdy, out_vld, zero_dig}), 0);
        in_word = 1'b1;
        w_ncyc = 0; w_dcnt = 0; w_zcnt = 0; w_first_at = -1;
      end else if (busy) begin
        if (stall) chk("stall_quiet", int'({dig_rdy, out_vld, out_first, out_last}), 0);
        else begin
          if (dig_rdy) w_dcnt++;
          if (zero_dig) w_zcnt++;
          if (out_first) w_first_at = w_ncyc;
          w_ncyc++;
        end
        if (out_vld) begin
          if (exp_beats.size() == 0) chk("unexpected_beat", 1, 0);
          else begin
            bt = exp_beats.pop_front();
            chk("out_id", int'(out_id), bt.id);
            chk("out_first", int'(out_first), bt.first);
            chk("out_last", int'(out_last), bt.last);
          end
        end
      end else begin
        chk("idle_quiet", int'({gnt, out_vld, dig_rdy, zero_dig}), 0);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (stall_en) stall = ($urandom_range(0, 3) == 0);
  endtask

  task automatic wait_clears(input int tgt);
    int n;
    n = 0;
    while (clr_cnt < tgt && n < 2000) begin tick(); n++; end
    if (clr_cnt < tgt) chk("clear_timeout", clr_cnt, tgt);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 2000) begin tick(); n++; end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    exp_beats.delete();
    exp_gnts.delete();
    m_ptr = NREQ - 1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int t0, b0, c0;
    int clr_n, clr_idx, dig_n, dig_first, zero_n, zero_idx, vld_n, vld_first, last_idx, idle_idx;
    int gnt0;
    int ord2[5];
    int ord4[6];
    logic [3:0] r;

    fork monitor(); join_none

    // Reset values while rst_n is low.
    #12;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sub_clr", int'(sub_clr), 1);
    chk("rst_outs", int'({dig_rdy, zero_dig, out_vld, out_first, out_last}), 0);
    chk("rst_out_id", int'(out_id), 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    // Single word, req held one cycle.
    model_word(4'b0001);
    req = 4'b0001;
    tick();
    req = 4'b0000;
    clr_n = 0; clr_idx = -1; dig_n = 0; dig_first = -1; zero_n = 0; zero_idx = -1;
    vld_n = 0; vld_first = -1; last_idx = -1; idle_idx = -1; gnt0 = -1;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      if (c == 0) gnt0 = int'(gnt);
      if (sub_clr) begin clr_n++; if (clr_idx < 0) clr_idx = c; end
      if (dig_rdy) begin dig_n++; if (dig_first < 0) dig_first = c; end
      if (zero_dig) begin zero_n++; if (zero_idx < 0) zero_idx = c; end
      if (out_vld) begin vld_n++; if (vld_first < 0) vld_first = c; end
      if (out_last) last_idx = c;
      if (!busy && idle_idx < 0) idle_idx = c;
    end
    chk("t1_gnt", gnt0, 1);
    chk("t1_clear_count", clr_n, 1);
    chk("t1_clear_idx", clr_idx, 0);
    chk("t1_dig_rdy_count", dig_n, NDIG);
    chk("t1_dig_rdy_first", dig_first, 1);
    chk("t1_zero_count", zero_n, DELTA);
    chk("t1_zero_idx", zero_idx, 1 + NDIG);
    chk("t1_vld_count", vld_n, NDIG);
    chk("t1_vld_first", vld_first, 1 + DELTA);
    chk("t1_last_idx", last_idx, NDIG + DELTA);
    chk("t1_idle_idx", idle_idx, WLEN);
    tick();

    // All requesters held: back-to-back words.
    do_reset();
    got_gnts.delete();
    for (int i = 0; i < 5; i++) model_word(4'b1111);
    c0 = clr_cnt; t0 = cyc; b0 = busy_cyc;
    req = 4'b1111;
    wait_clears(c0 + 5);
    req = 4'b0000;
    wait_idle();
    chk("t2_elapsed", cyc - t0, 1 + 5 * WLEN);
    chk("t2_busy_cycles", busy_cyc - b0, 5 * WLEN);
    chk("t2_words", got_gnts.size(), 5);
`ifdef MRHY4_SCHED_PRIO_EN
    ord2 = '{0, 0, 0, 0, 0};
`else
    ord2 = '{0, 1, 2, 3, 0};
`endif
    for (int i = 0; i < 5; i++)
      if (i < got_gnts.size()) chk("t2_order", got_gnts[i], ord2[i]);
    tick();

    // Three-cycle stall at RUN digit 4.
    model_word(4'b0100);
    req = 4'b0100;
    tick();
    req = 4'b0000;
    b0 = busy_cyc;
    repeat (5) tick();
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    wait_idle();
    tick();
    chk("t3_word_len", busy_cyc - b0, WLEN + 3);

    // Priority / round-robin order with req=1011 then 1010.
    do_reset();
    got_gnts.delete();
    for (int i = 0; i < 3; i++) model_word(4'b1011);
    c0 = clr_cnt;
    req = 4'b1011;
    wait_clears(c0 + 3);
    for (int i = 0; i < 3; i++) model_word(4'b1010);
    req = 4'b1010;
    wait_clears(c0 + 6);
    req = 4'b0000;
    wait_idle();
`ifdef MRHY4_SCHED_PRIO_EN
    ord4 = '{0, 0, 0, 1, 3, 1};
`else
    ord4 = '{0, 1, 3, 1, 3, 1};
`endif
    chk("t4_words", got_gnts.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < got_gnts.size()) chk("t4_order", got_gnts[i], ord4[i]);
    tick();

    // Random request patterns with random stalls.
    stall_en = 1'b1;
    for (int p = 0; p < 8; p++) begin
      int k;
      r = 4'($urandom_range(1, 15));
      k = $urandom_range(1, 3);
      for (int i = 0; i < k; i++) model_word(r);
      c0 = clr_cnt;
      req = r;
      wait_clears(c0 + k);
      req = 4'b0000;
      wait_idle();
      tick();
    end
    stall_en = 1'b0;
    stall = 1'b0;
    tick();

    // Reset mid-word aborts the word.
    r = 4'($urandom_range(1, 15));
    model_word(r);
    req = r;
    tick();
    req = 4'b0000;
    repeat (6) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_gnt", int'(gnt), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_sub_clr", int'(sub_clr), 1);
    chk("t6_outs", int'({dig_rdy, zero_dig, out_vld, out_first, out_last}), 0);
    chk("t6_sel_id", int'({sel, out_id}), 0);
    exp_beats.delete();
    exp_gnts.delete();
    m_ptr = NREQ - 1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    model_word(4'b0010);
    req = 4'b0010;
    tick();
    req = 4'b0000;
    @(negedge clk);
    chk("t6_regrant", int'(gnt), 2);
    wait_idle();
    repeat (3) tick();

    chk("beats_left", exp_beats.size(), 0);
    chk("grants_left", exp_gnts.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mrhy4_sub_sched.md
MRHY4_SUB_SCHED -- requirements
Module: mrhy4_sub_sched

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requesters sharing one digit-serial mrHY4 subtractor (2..8).
REQ-002 The block SHALL have parameter NDIG, default 16, meaning the number of radix-4 signed digits per word (4..64).
REQ-003 The block SHALL have parameter DELTA, default 1, meaning the online delay of the subtractor in cycles (1..3).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, an asynchronous, active-low reset.
REQ-006 The block SHALL have port req, input, NREQ bits, per-requester word request, level.
REQ-007 The block SHALL have port stall, input, 1 bit, a global freeze of digit sequencing.
REQ-008 The block SHALL have port gnt, output, NREQ bits, one-hot grant, held for the whole word including flush.
REQ-009 The block SHALL have port sel, output, clog2(NREQ) bits, the operand-mux select equal to the index of gnt.
REQ-010 The block SHALL have port dig_rdy, output, 1 bit: the granted requester's digit is consumed this cycle.
REQ-011 The block SHALL have port zero_dig, output, 1 bit, forcing the operand mux to digit value 0 during flush.
REQ-012 The block SHALL have port sub_clr, output, 1 bit, the synchronous clear of the subtractor's internal registers.
REQ-013 The block SHALL have ports out_vld, out_first and out_last, outputs, 1 bit each, marking valid result digits and the word's first and last result digit.
REQ-014 The block SHALL have port out_id, output, clog2(NREQ) bits, the owner of the current result digit.
REQ-015 The block SHALL have port busy, output, 1 bit, high in any state other than IDLE.

Function
REQ-016 The FSM SHALL use the states IDLE, CLEAR, RUN and FLUSH.
REQ-017 In IDLE with any req bit set, the block SHALL arbitrate, register gnt/sel and enter CLEAR on the next edge; with req equal to 0 it SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin: search starts at the index after the last granted one, and the pointer updates only when a grant is issued.
REQ-019 CLEAR SHALL last exactly 1 cycle, with sub_clr=1, dig_rdy=0, out_vld=0; it is not affected by stall.
REQ-020 RUN SHALL last NDIG non-stalled cycles; dig_rdy=1 when stall=0, and a digit counter counts 0..NDIG-1.
REQ-021 FLUSH SHALL last DELTA non-stalled cycles; zero_dig=1 throughout and dig_rdy=0.
REQ-022 An elapsed counter k SHALL cover 0..NDIG+DELTA-1 over non-stalled RUN+FLUSH cycles; out_vld=1 exactly when k>=DELTA and stall=0, giving NDIG result digits per word.
REQ-023 out_first SHALL assert with the out_vld where k=DELTA, and out_last with the out_vld where k=NDIG+DELTA-1; out_id SHALL equal sel during RUN/FLUSH.
REQ-024 With stall=1 in RUN or FLUSH, the counters, state and gnt SHALL hold, and dig_rdy, out_vld, out_first and out_last SHALL be 0.
REQ-025 On the last FLUSH cycle: if any req bit is set, the block SHALL arbitrate and go directly to CLEAR (zero idle cycles); otherwise it SHALL go to IDLE and gnt SHALL become 0.
REQ-026 req SHALL be sampled only at arbitration points; a deasserted req mid-word SHALL be ignored and the word SHALL complete.
REQ-027 A single requester holding req continuously SHALL be re-granted back-to-back.

Reset
REQ-028 While rst_n=0, the block SHALL be in IDLE with gnt=0, sel=0, dig_rdy=0, zero_dig=0, out_vld=0, out_first=0, out_last=0, out_id=0, busy=0, counters=0, RR pointer=NREQ-1 (so requester 0 wins first), and sub_clr=1.
REQ-029 Reset assertion mid-word SHALL abort the word immediately with no out_last; after release, the first grant SHALL go through CLEAR.

Configuration
REQ-030 With macro MRHY4_SCHED_PRIO_EN defined, req[0] SHALL win every arbitration point when set and leave the RR pointer unchanged, while other requesters use round-robin; without the macro, all requesters SHALL be pure round-robin; in neither case is a word preempted.

Verification
REQ-031 NDIG=8, DELTA=1, req=0001 held one cycle after reset: gnt=0001, one sub_clr cycle, 8 dig_rdy cycles, then 1 zero_dig cycle, out_vld on 8 cycles starting at the 2nd RUN cycle, with out_last in FLUSH.
REQ-032 req=1111 held: the grant order SHALL be 0,1,2,3,0, back-to-back with exactly one CLEAR cycle between words and busy constant 1.
REQ-033 A stall pulse of 3 cycles at RUN digit 4: the counters SHALL freeze, out_vld=0 for 3 cycles, and the word SHALL end 3 cycles later with 8 result digits total.
REQ-034 rst_n pulsed low at RUN digit 5: outputs SHALL be at reset values asynchronously, with no out_last; a subsequent req=0010 SHALL produce gnt=0010 via CLEAR.
REQ-035 MRHY4_SCHED_PRIO_EN defined, req=1011 held: the grant order SHALL be 0,0,0...; when req[0] drops, the order SHALL continue 1,3,1 per round-robin. Without the macro, the order SHALL be 0,1,3.
